turn_timer_scoreboard: RTL and testbench

- Game-state stage sitting directly upstream of the seven-segment HUD.
- Tracks player scores, the active player, a per-turn countdown timer (BCD) and the winner of a card-matching game.
- Consumes match results from the board/card logic; emits 4-bit digit codes wired straight into the HUD's seven-segment decoders.
- Any code >9 renders as "P" on the HUD.

---
 rtl/turn_timer_scoreboard.sv | 166 ++++++++++++++++
 tb/tb_turn_timer_scoreboard.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/turn_timer_scoreboard.sv
// Turn/timer/score game-state stage feeding the seven-segment HUD digit decoders.
// Optional pause input and behaviour enabled by defining HUD_PAUSE_EN.
module turn_timer_scoreboard #(
  parameter int CLK_HZ      = 50000000,
  parameter int TURN_SECS   = 15,
  parameter int TOTAL_PAIRS = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       result_valid,
  input  logic       result_match,
`ifdef HUD_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] cur_player,
  output logic [3:0] timer_tens,
  output logic [3:0] timer_ones,
  output logic [3:0] winner,
  output logic       game_over
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_HZ - 1);
  localparam logic [3:0]    RELOAD_TENS = 4'(TURN_SECS / 10);
  localparam logic [3:0]    RELOAD_ONES = 4'(TURN_SECS % 10);
  localparam logic [3:0]    PAIRS_LAST  = 4'(TOTAL_PAIRS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_SWAP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    p1_q, p1_d;
  logic [3:0]    p2_q, p2_d;
  logic          cur_q, cur_d;           // 0 = player 1, 1 = player 2
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    winner_q, winner_d;
  logic          over_q, over_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    pairs_q, pairs_d;
  logic          run;

`ifdef HUD_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    cur_d    = cur_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    winner_d = winner_q;
    over_d   = over_q;
    presc_d  = presc_q;
    pairs_d  = pairs_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_TURN;
          p1_d     = 4'd0;
          p2_d     = 4'd0;
          cur_d    = 1'b0;
          tens_d   = RELOAD_TENS;
          ones_d   = RELOAD_ONES;
          winner_d = 4'd0;
          over_d   = 1'b0;
          presc_d  = '0;
          pairs_d  = 4'd0;
        end
      end

      ST_TURN: begin
        if (run) begin
          // A result on the same cycle as a tick wins; the tick is dropped.
          if (result_valid) begin
            if (result_match) begin
              if (cur_q) p2_d = p2_q + 4'd1;
              else       p1_d = p1_q + 4'd1;
              pairs_d = pairs_q + 4'd1;
              if (pairs_d == PAIRS_LAST) begin
                state_d  = ST_DONE;
                over_d   = 1'b1;
                winner_d = (p1_d > p2_d) ? 4'd1 :
                           (p2_d > p1_d) ? 4'd2 : 4'd0;
              end else begin
                tens_d  = RELOAD_TENS;
                ones_d  = RELOAD_ONES;
                presc_d = '0;
              end
            end else begin
              state_d = ST_SWAP;
            end
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end
            if (tens_q == 4'd0 && ones_q == 4'd1) state_d = ST_SWAP;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      ST_SWAP: begin
        cur_d   = ~cur_q;
        tens_d  = RELOAD_TENS;
        ones_d  = RELOAD_ONES;
        presc_d = '0;
        state_d = ST_TURN;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      p1_q     <= 4'd0;
      p2_q     <= 4'd0;
      cur_q    <= 1'b0;
      tens_q   <= RELOAD_TENS;
      ones_q   <= RELOAD_ONES;
      winner_q <= 4'd0;
      over_q   <= 1'b0;
      presc_q  <= '0;
      pairs_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      cur_q    <= cur_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      winner_q <= winner_d;
      over_q   <= over_d;
      presc_q  <= presc_d;
      pairs_q  <= pairs_d;
    end
  end

  assign p1_score   = p1_q;
  assign p2_score   = p2_q;
  assign cur_player = cur_q ? 4'd2 : 4'd1;
  assign timer_tens = tens_q;
  assign timer_ones = ones_q;
  assign winner     = winner_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_turn_timer_scoreboard.sv
// Directed bench for turn_timer_scoreboard with CLK_HZ=4, TURN_SECS=15, TOTAL_PAIRS=2.
// Build with HUD_PAUSE_EN defined to exercise the pause scenario as well.
module tb_turn_timer_scoreboard;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       result_valid = 1'b0;
  logic       result_match = 1'b0;
`ifdef HUD_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [3:0] p1_score, p2_score, cur_player, timer_tens, timer_ones, winner;
  logic       game_over;

  int checks = 0;
  int failures = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  turn_timer_scoreboard #(.CLK_HZ(4), .TURN_SECS(15), .TOTAL_PAIRS(2)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .result_valid(result_valid),
    .result_match(result_match),
`ifdef HUD_PAUSE_EN
    .pause       (pause),
`endif
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .cur_player  (cur_player),
    .timer_tens  (timer_tens),
    .timer_ones  (timer_ones),
    .winner      (winner),
    .game_over   (game_over)
  );

  // Advance n rising edges and settle 1ns past the last one.
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle(1);
    start = 1'b0;
  endtask

  task automatic pulse_result(input logic m);
    result_valid = 1'b1;
    result_match = m;
    cycle(1);
    result_valid = 1'b0;
    result_match = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycle(20);
    checks++; if (p1_score !== 4'd0) begin failures++; $display("FAIL reset_p1 got=%0d exp=0", p1_score); end
    checks++; if (p2_score !== 4'd0) begin failures++; $display("FAIL reset_p2 got=%0d exp=0", p2_score); end
    checks++; if (cur_player !== 4'd1) begin failures++; $display("FAIL reset_cur got=%0d exp=1", cur_player); end
    checks++; if (timer_tens !== 4'd1 || timer_ones !== 4'd5) begin failures++; $display("FAIL reset_timer got=%0d/%0d exp=1/5", timer_tens, timer_ones); end
    checks++; if (winner !== 4'd0) begin failures++; $display("FAIL reset_winner got=%0d exp=0", winner); end
    checks++; if (game_over !== 1'b0) begin failures++; $display("FAIL reset_over got=%0d exp=0", game_over); end
    $display("test_reset: idle 20 cycles done");
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_start();
    cycle(4);
    checks++; if (timer_tens !== 4'd1 || timer_ones !== 4'd4) begin failures++; $display("FAIL timeout_first_tick got=%0d/%0d exp=1/4", timer_tens, timer_ones); end
    cycle(36);
    checks++; if (timer_tens !== 4'd0 || timer_ones !== 4'd5) begin failures++; $display("FAIL timeout_borrow got=%0d/%0d exp=0/5", timer_tens, timer_ones); end
    cycle(20);
    checks++; if (timer_tens !== 4'd0 || timer_ones !== 4'd0) begin failures++; $display("FAIL timeout_zero got=%0d/%0d exp=0/0", timer_tens, timer_ones); end
    checks++; if (cur_player !== 4'd1) begin failures++; $display("FAIL timeout_swap_cur got=%0d exp=1", cur_player); end
    cycle(1);
    checks++; if (cur_player !== 4'd2) begin failures++; $display("FAIL timeout_cur got=%0d exp=2", cur_player); end
    checks++; if (timer_tens !== 4'd1 || timer_ones !== 4'd5) begin failures++; $display("FAIL timeout_reload got=%0d/%0d exp=1/5", timer_tens, timer_ones); end
    $display("test_timeout: 60-cycle turn expiry done");
  endtask

  task automatic test_no_match();
    do_reset();
    pulse_start();
    cycle(2);
    pulse_result(1'b0);
    cycle(1);
    checks++; if (cur_player !== 4'd2) begin failures++; $display("FAIL nomatch_cur got=%0d exp=2", cur_player); end
    checks++; if (timer_tens !== 4'd1 || timer_ones !== 4'd5) begin failures++; $display("FAIL nomatch_timer got=%0d/%0d exp=1/5", timer_tens, timer_ones); end
    checks++; if (p1_score !== 4'd0 || p2_score !== 4'd0) begin failures++; $display("FAIL nomatch_scores got=%0d/%0d exp=0/0", p1_score, p2_score); end
    $display("test_no_match: miss hands turn to player 2");
  endtask

  task automatic test_match_game();
    do_reset();
    pulse_start();
    pulse_result(1'b1);
    checks++; if (p1_score !== 4'd1) begin failures++; $display("FAIL game_p1_first got=%0d exp=1", p1_score); end
    checks++; if (cur_player !== 4'd1 || game_over !== 1'b0) begin failures++; $display("FAIL game_mid got cur=%0d over=%0d exp cur=1 over=0", cur_player, game_over); end
    cycle(1);
    start = 1'b1;  // ignored while in TURN
    cycle(1);
    start = 1'b0;
    pulse_result(1'b1);
    checks++; if (p1_score !== 4'd2) begin failures++; $display("FAIL game_p1_second got=%0d exp=2", p1_score); end
    checks++; if (game_over !== 1'b1 || winner !== 4'd1) begin failures++; $display("FAIL game_done got over=%0d win=%0d exp over=1 win=1", game_over, winner); end
    checks++; if (cur_player !== 4'd1) begin failures++; $display("FAIL game_cur got=%0d exp=1", cur_player); end
    pulse_result(1'b1);
    cycle(2);
    checks++; if (p1_score !== 4'd2 || game_over !== 1'b1) begin failures++; $display("FAIL done_ignore got p1=%0d over=%0d exp p1=2 over=1", p1_score, game_over); end
    pulse_start();
    checks++; if (p1_score !== 4'd0 || game_over !== 1'b0 || winner !== 4'd0) begin failures++; $display("FAIL restart got p1=%0d over=%0d win=%0d exp 0/0/0", p1_score, game_over, winner); end
    checks++; if (timer_tens !== 4'd1 || timer_ones !== 4'd5 || cur_player !== 4'd1) begin failures++; $display("FAIL restart_timer got %0d/%0d cur=%0d exp 1/5 cur=1", timer_tens, timer_ones, cur_player); end
    $display("test_match_game: P1 sweeps, restart from DONE");
  endtask

  task automatic test_winner_p2();
    do_reset();
    pulse_start();
    pulse_result(1'b0);       // P1 misses, SWAP next
    pulse_result(1'b1);       // presented during SWAP: ignored
    checks++; if (p2_score !== 4'd0 || cur_player !== 4'd2) begin failures++; $display("FAIL swap_ignore got p2=%0d cur=%0d exp p2=0 cur=2", p2_score, cur_player); end
    pulse_result(1'b1);
    pulse_result(1'b1);
    checks++; if (p2_score !== 4'd2 || p1_score !== 4'd0) begin failures++; $display("FAIL p2win_scores got %0d/%0d exp 0/2", p1_score, p2_score); end
    checks++; if (winner !== 4'd2 || game_over !== 1'b1) begin failures++; $display("FAIL p2win got win=%0d over=%0d exp win=2 over=1", winner, game_over); end
    $display("test_winner_p2: P2 wins after swap");
  endtask

  task automatic test_tie();
    do_reset();
    pulse_start();
    pulse_result(1'b1);
    pulse_result(1'b0);
    cycle(1);
    pulse_result(1'b1);
    checks++; if (p1_score !== 4'd1 || p2_score !== 4'd1) begin failures++; $display("FAIL tie_scores got %0d/%0d exp 1/1", p1_score, p2_score); end
    checks++; if (winner !== 4'd0 || game_over !== 1'b1) begin failures++; $display("FAIL tie got win=%0d over=%0d exp win=0 over=1", winner, game_over); end
    $display("test_tie: 1-1 gives winner 0");
  endtask

  task automatic test_tick_collision();
    do_reset();
    pulse_start();
    cycle(59);
    checks++; if (timer_tens !== 4'd0 || timer_ones !== 4'd1) begin failures++; $display("FAIL collide_pre got=%0d/%0d exp=0/1", timer_tens, timer_ones); end
    pulse_result(1'b1);       // lands on the final tick edge
    checks++; if (p1_score !== 4'd1) begin failures++; $display("FAIL collide_p1 got=%0d exp=1", p1_score); end
    checks++; if (timer_tens !== 4'd1 || timer_ones !== 4'd5) begin failures++; $display("FAIL collide_timer got=%0d/%0d exp=1/5", timer_tens, timer_ones); end
    cycle(1);
    checks++; if (cur_player !== 4'd1 || game_over !== 1'b0) begin failures++; $display("FAIL collide_noswap got cur=%0d over=%0d exp cur=1 over=0", cur_player, game_over); end
    $display("test_tick_collision: result beats tick");
  endtask

  task automatic test_reset_mid_turn();
    // Continues from test_tick_collision with p1_score=1 mid-TURN.
    cycle(2);
    do_reset();
    checks++; if (p1_score !== 4'd0 || p2_score !== 4'd0) begin failures++; $display("FAIL midrst_scores got %0d/%0d exp 0/0", p1_score, p2_score); end
    checks++; if (cur_player !== 4'd1 || winner !== 4'd0 || game_over !== 1'b0) begin failures++; $display("FAIL midrst_state got cur=%0d win=%0d over=%0d exp 1/0/0", cur_player, winner, game_over); end
    checks++; if (timer_tens !== 4'd1 || timer_ones !== 4'd5) begin failures++; $display("FAIL midrst_timer got=%0d/%0d exp=1/5", timer_tens, timer_ones); end
    cycle(8);
    checks++; if (timer_tens !== 4'd1 || timer_ones !== 4'd5) begin failures++; $display("FAIL midrst_idle got=%0d/%0d exp=1/5", timer_tens, timer_ones); end
    $display("test_reset_mid_turn: back to IDLE values");
  endtask

`ifdef HUD_PAUSE_EN
  task automatic test_pause();
    do_reset();
    pulse_start();
    cycle(5);                 // one tick done, prescaler at 1
    pause = 1'b1;
    cycle(20);
    checks++; if (timer_tens !== 4'd1 || timer_ones !== 4'd4) begin failures++; $display("FAIL pause_hold got=%0d/%0d exp=1/4", timer_tens, timer_ones); end
    pulse_result(1'b1);
    checks++; if (p1_score !== 4'd0) begin failures++; $display("FAIL pause_result got=%0d exp=0", p1_score); end
    pause = 1'b0;
    cycle(3);
    checks++; if (timer_tens !== 4'd1 || timer_ones !== 4'd3) begin failures++; $display("FAIL pause_resume got=%0d/%0d exp=1/3", timer_tens, timer_ones); end
    $display("test_pause: timer frozen while paused");
  endtask
`endif

  initial begin
    test_reset();
    test_timeout();
    test_no_match();
    test_match_game();
    test_winner_p2();
    test_tie();
    test_tick_collision();
    test_reset_mid_turn();
`ifdef HUD_PAUSE_EN
    test_pause();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
